// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Sequences one DSP48A1-style slice (A1/B1/M/P/OPMODE registered, A0/B0
// bypassed) as an N-term unsigned multiply-accumulate engine. A job command
// sets the product count. Operand pairs are then streamed straight into the
// slice. OPMODE and CEP are generated so that each product reaches P exactly
// once.
//
// Optional feature: define DSP_SEQ_SAT_EN to saturate `result` when the slice
// sum does not fit in RES_W bits. That build also adds a `sat` output that
// pulses with `done`. Without the macro, `result` is the truncated P value.
//
// Operand handshake: a pair is accepted on a rising edge where
// s_valid && s_ready. s_ready is high only in RUN while products remain. The
// source may hold s_valid low for any number of cycles.

module dsp_mac_sequencer #(
    parameter int LEN_W = 16,
    parameter int RES_W = 48   // must be <= 48
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    output logic [17:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic [47:0]      dsp_C,
    output logic [17:0]      dsp_D,
    output logic [7:0]       dsp_OPMODE,
    output logic             dsp_CEA,
    output logic             dsp_CEB,
    output logic             dsp_CEM,
    output logic             dsp_CEOPMODE,
    output logic             dsp_CEP,
    input  logic [47:0]      dsp_P
`ifdef DSP_SEQ_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // First product clears the accumulator (X=M, Z=0).
    // Later products add M to the fed-back P.
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    logic [1:0]       state;
    logic [LEN_W-1:0] remaining;
    logic             first;
    logic [1:0]       vp;
    logic [7:0]       opmode_q;
    logic [RES_W-1:0] result_q;
    logic             accept;
    logic [RES_W-1:0] p_capture;

    assign s_ready = (state == RUN) && (remaining != '0);
    assign accept  = s_valid & s_ready;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign result  = result_q;

    // Operands go straight to the A1/B1 registers. The slice clock enables
    // follow the accept, and the M/OPMODE registers stay enabled for the job.
    assign dsp_A        = s_a;
    assign dsp_B        = s_b;
    assign dsp_C        = '0;
    assign dsp_D        = '0;
    assign dsp_CEA      = accept;
    assign dsp_CEB      = accept;
    assign dsp_CEM      = busy;
    assign dsp_CEOPMODE = busy;
    assign dsp_CEP      = vp[1];
    assign dsp_OPMODE   = opmode_q;

`ifdef DSP_SEQ_SAT_EN
    logic p_ovf;
    logic sat_q;
    // A 49-bit compare avoids wrapping the limit when RES_W is 48.
    assign p_ovf     = ({1'b0, dsp_P} >= (49'd1 << RES_W));
    assign p_capture = p_ovf ? '1 : dsp_P[RES_W-1:0];
    assign sat       = sat_q;
`else
    assign p_capture = dsp_P[RES_W-1:0];
`endif

    // Track each accept through the A1/B1 and M stages, so that CEP fires
    // only for real products. A stall leaves a bubble, and a held M is
    // never added twice.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            vp       <= 2'b00;
            opmode_q <= 8'h00;
        end else begin
            vp <= {vp[0], accept};
            if (accept) begin
                opmode_q <= first ? OPM_FIRST : OPM_ACC;
            end
        end
    end

    // Job control: command intake, product counting, draining the slice
    // pipeline, and capturing the final P.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            remaining <= '0;
            first     <= 1'b0;
            result_q  <= '0;
`ifdef DSP_SEQ_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
`ifdef DSP_SEQ_SAT_EN
            sat_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            remaining <= len;
                            first     <= 1'b1;
                            state     <= RUN;
                        end else begin
                            result_q <= '0;
                            state    <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining <= remaining - LEN_W'(1);
                        first     <= 1'b0;
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // vp empty means the last CEP cycle has passed.
                    // P now holds the final sum.
                    if (vp == 2'b00) begin
                        result_q <= p_capture;
`ifdef DSP_SEQ_SAT_EN
                        sat_q    <= p_ovf;
`endif
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Testbench for dsp_mac_sequencer. A behavioural DSP48A1-style slice model
// (A1/B1, M, OPMODE and P registers) closes the loop. Expected sums are
// computed from the operands and queued when a job is driven. They are
// popped and compared when done is seen.

module tb_dsp_mac_sequencer;

`ifdef DSP_SEQ_SAT_EN
    localparam int RES_W = 36;
`else
    localparam int RES_W = 48;
`endif
    localparam int LEN_W = 16;

    logic             clk;
    logic             RST;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;
    logic             s_valid;
    logic             s_ready;
    logic [17:0]      s_a;
    logic [17:0]      s_b;
    logic [17:0]      dsp_A;
    logic [17:0]      dsp_B;
    logic [47:0]      dsp_C;
    logic [17:0]      dsp_D;
    logic [7:0]       dsp_OPMODE;
    logic             dsp_CEA;
    logic             dsp_CEB;
    logic             dsp_CEM;
    logic             dsp_CEOPMODE;
    logic             dsp_CEP;
    logic [47:0]      dsp_P;
`ifdef DSP_SEQ_SAT_EN
    logic             sat;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cea_count = 0;
    logic cep_log [0:4095];
    logic [RES_W-1:0] exp_q[$];

    dsp_mac_sequencer #(.LEN_W(LEN_W), .RES_W(RES_W)) dut (
        .clk(clk), .RST(RST), .start(start), .len(len),
        .busy(busy), .done(done), .result(result),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_C(dsp_C), .dsp_D(dsp_D),
        .dsp_OPMODE(dsp_OPMODE), .dsp_CEA(dsp_CEA), .dsp_CEB(dsp_CEB),
        .dsp_CEM(dsp_CEM), .dsp_CEOPMODE(dsp_CEOPMODE), .dsp_CEP(dsp_CEP),
        .dsp_P(dsp_P)
`ifdef DSP_SEQ_SAT_EN
        , .sat(sat)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < 4096) cep_log[cyc] <= dsp_CEP;
        if (dsp_CEA) cea_count <= cea_count + 1;
    end

    // ---------------- slice model ----------------
    logic [17:0] sl_a1 = '0;
    logic [17:0] sl_b1 = '0;
    logic [35:0] sl_m  = '0;
    logic [7:0]  sl_op = '0;
    logic [47:0] sl_p  = '0;

    always @(posedge clk) begin
        if (dsp_CEA) sl_a1 <= dsp_A;
        if (dsp_CEB) sl_b1 <= dsp_B;
        if (dsp_CEM) sl_m <= 36'(sl_a1) * 36'(sl_b1);
        if (dsp_CEOPMODE) sl_op <= dsp_OPMODE;
        if (dsp_CEP)
            sl_p <= ((sl_op[3:2] == 2'b10) ? sl_p : 48'd0) +
                    ((sl_op[1:0] == 2'b01) ? {12'd0, sl_m} : 48'd0);
    end
    assign dsp_P = sl_p;

    // Expected result from a full 48-bit slice sum.
    function automatic logic [RES_W-1:0] fold(input logic [47:0] s);
`ifdef DSP_SEQ_SAT_EN
        if ({1'b0, s} >= (49'd1 << RES_W)) return '1;
`endif
        return s[RES_W-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        RST = 1'b1; start = 1'b0; len = '0;
        s_valid = 1'b0; s_a = '0; s_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        RST = 1'b0;
    endtask

    task automatic start_job(input logic [LEN_W-1:0] l, output int sc);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(posedge clk);
        #1;
        sc    = cyc;
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [17:0] a, input logic [17:0] b,
                             input int gap, output int ac, output logic [7:0] om);
        bit got = 0;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1; s_a = a; s_b = b;
        ac = 0; om = 8'h00;
        for (int i = 0; i < 50; i++) begin
            if (s_ready === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL accept_timeout: s_ready=%b required 1", s_ready);
        end else begin
            @(posedge clk);
            #1;
            ac = cyc;
            om = dsp_OPMODE;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc, output bit ok);
        ok = 0; dc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc; ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL done_timeout: done=%b required 1 within 100 cycles", done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        checks++; if (result !== '0) begin failures++; $display("FAIL reset_result: got %0h want 0", result); end
        checks++; if (dsp_OPMODE !== 8'h00) begin failures++; $display("FAIL reset_opmode: got %0h want 0", dsp_OPMODE); end
        checks++;
        if ({dsp_CEP, dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEOPMODE} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ce: got %b want 00000", {dsp_CEP, dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEOPMODE});
        end
    endtask

    task automatic test_single();
        logic [17:0] av[4] = '{18'd1, 18'd3, 18'd5, 18'd7};
        logic [17:0] bv[4] = '{18'd2, 18'd4, 18'd6, 18'd8};
        logic [7:0]  ov[4] = '{8'h01, 8'h09, 8'h09, 8'h09};
        logic [7:0]  om[4];
        logic [47:0] s = '0;
        logic [RES_W-1:0] e;
        int sc, ac, dc;
        bit ok;
        for (int i = 0; i < 4; i++) s += 48'(av[i]) * 48'(bv[i]);
        start_job(16'd4, sc);
        exp_q.push_back(fold(s));
        for (int i = 0; i < 4; i++) send_pair(av[i], bv[i], 0, ac, om[i]);
        wait_done(dc, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (result !== e) begin failures++; $display("FAIL single_result: got %0d want %0d", result, e); end
            checks++; if (dc !== ac + 3) begin failures++; $display("FAIL single_done_latency: got %0d want %0d", dc - ac, 3); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (om[i] !== ov[i]) begin failures++; $display("FAIL single_opmode[%0d]: got %0h want %0h", i, om[i], ov[i]); end
        end
    endtask

    task automatic test_stall();
        logic [17:0] av[4] = '{18'd1, 18'd3, 18'd5, 18'd7};
        logic [17:0] bv[4] = '{18'd2, 18'd4, 18'd6, 18'd8};
        int acs[4];
        logic [7:0] om;
        logic [47:0] s = '0;
        logic [RES_W-1:0] e;
        int sc, dc;
        bit ok;
        for (int i = 0; i < 4; i++) s += 48'(av[i]) * 48'(bv[i]);
        start_job(16'd4, sc);
        exp_q.push_back(fold(s));
        for (int i = 0; i < 4; i++) send_pair(av[i], bv[i], (i == 2) ? 2 : 0, acs[i], om);
        wait_done(dc, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (result !== e) begin failures++; $display("FAIL stall_result: got %0d want %0d", result, e); end
        end
        checks++; if (cep_log[acs[1] + 1] !== 1'b1) begin failures++; $display("FAIL stall_cep_pair2: got %b want 1", cep_log[acs[1] + 1]); end
        checks++; if (cep_log[acs[1] + 2] !== 1'b0) begin failures++; $display("FAIL stall_cep_bubble0: got %b want 0", cep_log[acs[1] + 2]); end
        checks++; if (cep_log[acs[1] + 3] !== 1'b0) begin failures++; $display("FAIL stall_cep_bubble1: got %b want 0", cep_log[acs[1] + 3]); end
        checks++; if (cep_log[acs[2] + 1] !== 1'b1) begin failures++; $display("FAIL stall_cep_pair3: got %b want 1", cep_log[acs[2] + 1]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] om;
        logic [RES_W-1:0] e;
        int sc, ac, dc;
        bit ok;
        start_job(16'd2, sc);
        exp_q.push_back(fold(48'd12));
        repeat (2) send_pair(18'd2, 18'd3, 0, ac, om);
        wait_done(dc, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (result !== e) begin failures++; $display("FAIL b2b_job1: got %0d want %0d", result, e); end
        end
        start_job(16'd1, sc);
        exp_q.push_back(fold(48'd1));
        send_pair(18'd1, 18'd1, 0, ac, om);
        checks++; if (om !== 8'h01) begin failures++; $display("FAIL b2b_job2_opmode: got %0h want 01", om); end
        wait_done(dc, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (result !== e) begin failures++; $display("FAIL b2b_job2: got %0d want %0d", result, e); end
        end
    endtask

    task automatic test_len_zero();
        logic [RES_W-1:0] e;
        int sc, dc, cea0;
        bit ok;
        cea0 = cea_count;
        start_job(16'd0, sc);
        exp_q.push_back('0);
        wait_done(dc, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (result !== e) begin failures++; $display("FAIL len0_result: got %0d want %0d", result, e); end
            checks++; if (dc !== sc) begin failures++; $display("FAIL len0_latency: got %0d want 0 cycles after start edge", dc - sc); end
        end
        repeat (3) @(negedge clk);
        checks++; if (cea_count !== cea0) begin failures++; $display("FAIL len0_cea: got %0d accepts want 0", cea_count - cea0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL len0_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_midjob();
        logic [7:0] om;
        logic [RES_W-1:0] e;
        int sc, ac, dc, done_seen;
        bit ok;
        start_job(16'd5, sc);
        send_pair(18'd4, 18'd5, 0, ac, om);
        send_pair(18'd6, 18'd7, 0, ac, om);
        @(negedge clk);
        RST = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (result !== '0) begin failures++; $display("FAIL midrst_result: got %0d want 0", result); end
        checks++; if (dsp_OPMODE !== 8'h00) begin failures++; $display("FAIL midrst_opmode: got %0h want 0", dsp_OPMODE); end
        checks++;
        if ({done, s_ready, dsp_CEP, dsp_CEM, dsp_CEOPMODE} !== 5'b0) begin
            failures++;
            $display("FAIL midrst_ctrl: got %b want 00000", {done, s_ready, dsp_CEP, dsp_CEM, dsp_CEOPMODE});
        end
        @(negedge clk);
        RST = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL midrst_no_done: got %0d done cycles want 0", done_seen); end
        start_job(16'd1, sc);
        exp_q.push_back(fold(48'd81));
        send_pair(18'd9, 18'd9, 0, ac, om);
        wait_done(dc, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (result !== e) begin failures++; $display("FAIL midrst_newjob: got %0d want %0d", result, e); end
        end
    endtask

`ifdef DSP_SEQ_SAT_EN
    task automatic test_saturate();
        logic [7:0] om;
        logic [47:0] s;
        logic [RES_W-1:0] e;
        int sc, ac, dc;
        bit ok;
        s = 48'd2 * (48'h3FFFF * 48'h3FFFF);
        start_job(16'd2, sc);
        exp_q.push_back(fold(s));
        repeat (2) send_pair(18'h3FFFF, 18'h3FFFF, 0, ac, om);
        wait_done(dc, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (result !== e) begin failures++; $display("FAIL sat_result: got %0h want %0h", result, e); end
            checks++; if (sat !== 1'b1) begin failures++; $display("FAIL sat_flag: got %b want 1", sat); end
        end
        @(negedge clk);
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL sat_pulse: got %b want 0", sat); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_len_zero();
        test_reset_midjob();
`ifdef DSP_SEQ_SAT_EN
        test_saturate();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
